exe_unit_ctrl: RTL and testbench

EXE_UNIT_CTRL -- requirements
Module: exe_unit_ctrl

---
 rtl/exe_unit_ctrl.sv | 146 ++++++++++++++
 tb/tb_exe_unit_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_unit_ctrl.sv
// ----------------------------------------------------------------------------
// exe_unit_ctrl
//   Handshake controller for a fixed-latency execution unit. It accepts one
//   operation at a time, registers the operands toward the unit, waits out
//   the unit latency, captures the result/status, and holds the response
//   until the consumer takes it. It also counts responses with nonzero status.
//
// Parameters
//   m    operand/result width
//   n    operation code width
//   LAT  execution unit latency in clocks (1..15)
//
// Ports
//   i_clk, i_rsn                  clock, async active-low reset
//   i_req_valid / o_req_ready     request handshake (ready only in IDLE)
//   i_req_oper/argA/argB          request fields
//   o_oper/o_argA/o_argB          registered drive to the execution unit
//   i_result / i_status           execution unit outputs
//   o_rsp_valid / i_rsp_ready     response handshake (valid only in RESP)
//   o_rsp_result / o_rsp_status   captured response
//   o_err_cnt                     saturating count of nonzero-status responses
// ----------------------------------------------------------------------------
module exe_unit_ctrl #(
    parameter int m   = 4,
    parameter int n   = 2,
    parameter int LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [n-1:0] i_req_oper,
    input  logic [m-1:0] i_req_argA,
    input  logic [m-1:0] i_req_argB,
    output logic [n-1:0] o_oper,
    output logic [m-1:0] o_argA,
    output logic [m-1:0] o_argB,
    input  logic [m-1:0] i_result,
    input  logic [1:0]   i_status,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [m-1:0] o_rsp_result,
    output logic [1:0]   o_rsp_status,
    output logic [7:0]   o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [n-1:0]   r_oper;
    logic [m-1:0]   r_argA;
    logic [m-1:0]   r_argB;
    logic [m-1:0]   r_rsp_result;
    logic [1:0]     r_rsp_status;
    logic [7:0]     r_err_cnt;

    logic           w_accept;
    logic           w_capture;
    logic           w_rsp_exit;

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_oper       = r_oper;
    assign o_argA       = r_argA;
    assign o_argB       = r_argB;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_status = r_rsp_status;
    assign o_err_cnt    = r_err_cnt;

    assign w_accept   = i_req_valid & o_req_ready;
    // The counter runs LAT..0 over edges E1..E_LAT (E1 being the unit's own
    // input register); the result is valid on the edge after it reaches 0,
    // i.e. LAT+1 edges after the accept.
    assign w_capture  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_rsp_exit = (r_state == S_RESP) && i_rsp_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_WAIT;
            S_WAIT:  if (w_capture)  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_exit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait counter
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= LAT_CNT;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Operand drive: loaded on accept only, held otherwise
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_oper <= '0;
            r_argA <= '0;
            r_argB <= '0;
        end else if (w_accept) begin
            r_oper <= i_req_oper;
            r_argA <= i_req_argA;
            r_argB <= i_req_argB;
        end
    end

    // Response capture: held stable through RESP
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_rsp_result <= '0;
            r_rsp_status <= '0;
        end else if (w_capture) begin
            r_rsp_result <= i_result;
            r_rsp_status <= i_status;
        end
    end

    // Error counter, saturating at 255
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_err_cnt <= 8'd0;
        end else if (w_rsp_exit && r_rsp_status != 2'b00 && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_exe_unit_ctrl.sv
module tb_exe_unit_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rsn = 1'b0;

    // LAT=1 instance
    logic       req_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0] req_oper = '0, status = '0;
    logic [3:0] req_a = '0, req_b = '0, result = '0;
    logic       req_ready, rsp_valid;
    logic [1:0] oper_o, rsp_status;
    logic [3:0] arga_o, argb_o, rsp_result;
    logic [7:0] err_cnt;

    // LAT=3 instance
    logic       req_valid3 = 1'b0, rsp_ready3 = 1'b0;
    logic [1:0] req_oper3 = '0, status3 = '0;
    logic [3:0] req_a3 = '0, req_b3 = '0, result3 = '0;
    logic       req_ready3, rsp_valid3;
    logic [1:0] oper_o3, rsp_status3;
    logic [3:0] arga_o3, argb_o3, rsp_result3;
    logic [7:0] err_cnt3;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    exe_unit_ctrl #(.m(4), .n(2), .LAT(1)) u_dut1 (
        .i_clk(i_clk), .i_rsn(i_rsn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_oper(req_oper), .i_req_argA(req_a), .i_req_argB(req_b),
        .o_oper(oper_o), .o_argA(arga_o), .o_argB(argb_o),
        .i_result(result), .i_status(status),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
        .o_err_cnt(err_cnt)
    );

    exe_unit_ctrl #(.m(4), .n(2), .LAT(3)) u_dut3 (
        .i_clk(i_clk), .i_rsn(i_rsn),
        .i_req_valid(req_valid3), .o_req_ready(req_ready3),
        .i_req_oper(req_oper3), .i_req_argA(req_a3), .i_req_argB(req_b3),
        .o_oper(oper_o3), .o_argA(arga_o3), .o_argB(argb_o3),
        .i_result(result3), .i_status(status3),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3),
        .o_rsp_result(rsp_result3), .o_rsp_status(rsp_status3),
        .o_err_cnt(err_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int acc_cyc[$];

        // ---------------- reset values, before any clock
        #2;
        chk("rst_ready",  32'(req_ready), 32'd1);
        chk("rst_valid",  32'(rsp_valid), 32'd0);
        chk("rst_oper",   32'(oper_o), 32'd0);
        chk("rst_argA",   32'(arga_o), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_err",    32'(err_cnt), 32'd0);
        #5 i_rsn = 1'b1;   // released mid-cycle, before first edge at t=5? (t=7, next edge t=15)

        // ---------------- single op, LAT=1
        req_valid = 1'b1; req_oper = 2'b11; req_a = 4'b1111; req_b = 4'b0000;
        result = 4'hA; status = 2'b00;
        tick();  // E0
        req_valid = 1'b0;
        chk("t1_oper",  32'(oper_o), 32'h3);
        chk("t1_argA",  32'(arga_o), 32'hF);
        chk("t1_argB",  32'(argb_o), 32'h0);
        chk("t1_ready_e0", 32'(req_ready), 32'd0);
        tick();  // E1
        chk("t1_valid_e1", 32'(rsp_valid), 32'd0);
        tick();  // E2
        chk("t1_valid_e2", 32'(rsp_valid), 32'd1);
        chk("t1_result",   32'(rsp_result), 32'hA);
        chk("t1_status",   32'(rsp_status), 32'h0);
        rsp_ready = 1'b1;
        tick();  // exit
        rsp_ready = 1'b0;
        chk("t1_ready_after", 32'(req_ready), 32'd1);
        chk("t1_valid_after", 32'(rsp_valid), 32'd0);
        chk("t1_err",         32'(err_cnt), 32'd0);
        chk("t1_oper_hold",   32'(oper_o), 32'h3);

        // ---------------- LAT=3, consumer stalls for 5 cycles
        req_valid3 = 1'b1; req_oper3 = 2'b01; req_a3 = 4'h5; req_b3 = 4'h2;
        result3 = 4'h7; status3 = 2'b10;
        tick();  // E0
        req_valid3 = 1'b0;
        tick(); tick(); tick();  // E1..E3
        chk("t2_valid_e3", 32'(rsp_valid3), 32'd0);
        tick();  // E4
        chk("t2_valid_e4", 32'(rsp_valid3), 32'd1);
        chk("t2_result",   32'(rsp_result3), 32'h7);
        result3 = 4'h1; status3 = 2'b00;  // unit output changes; captured data must not
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid",  32'(rsp_valid3), 32'd1);
            chk("t2_hold_result", 32'(rsp_result3), 32'h7);
            chk("t2_hold_status", 32'(rsp_status3), 32'h2);
        end
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        chk("t2_idle",  32'(req_ready3), 32'd1);
        chk("t2_valid_off", 32'(rsp_valid3), 32'd0);
        chk("t2_err",   32'(err_cnt3), 32'd1);

        // ---------------- rsp_ready while idle, negative operands, early rsp_ready
        rsp_ready = 1'b1;
        tick();
        chk("t5_idle_ready", 32'(req_ready), 32'd1);
        chk("t5_idle_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1; req_oper = 2'b10; req_a = 4'b1000; req_b = 4'b0111;
        result = 4'hC; status = 2'b00;
        tick();  // E0 (rsp_ready still high)
        req_valid = 1'b0;
        chk("t5_argA", 32'(arga_o), 32'h8);
        chk("t5_argB", 32'(argb_o), 32'h7);
        tick();  // E1
        chk("t5_wait_valid", 32'(rsp_valid), 32'd0);
        chk("t5_wait_ready", 32'(req_ready), 32'd0);
        tick();  // E2
        chk("t5_resp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_resp_result", 32'(rsp_result), 32'hC);
        tick();  // exits immediately
        chk("t5_back_idle", 32'(req_ready), 32'd1);

        // ---------------- req_valid held, 3 accepts 4 cycles apart
        req_valid = 1'b1; req_oper = 2'b01; req_a = 4'h3; req_b = 4'h4;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) acc_cyc.push_back(c);
            tick();
        end
        req_valid = 1'b0;
        chk("t3_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("t3_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            chk("t3_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        end
        rsp_ready = 1'b0;

        // ---------------- reset mid-WAIT on LAT=3 instance
        req_valid3 = 1'b1; req_oper3 = 2'b10; req_a3 = 4'h5; req_b3 = 4'h3;
        result3 = 4'h9; status3 = 2'b01;
        tick();  // E0
        req_valid3 = 1'b0;
        chk("t4_loaded", 32'(oper_o3), 32'h2);
        tick();  // E1, in WAIT
        #2 i_rsn = 1'b0;
        #1;
        chk("t4_rst_oper",   32'(oper_o3), 32'd0);
        chk("t4_rst_argA",   32'(arga_o3), 32'd0);
        chk("t4_rst_argB",   32'(argb_o3), 32'd0);
        chk("t4_rst_result", 32'(rsp_result3), 32'd0);
        chk("t4_rst_err",    32'(err_cnt3), 32'd0);
        chk("t4_rst_ready",  32'(req_ready3), 32'd1);
        chk("t4_rst_valid",  32'(rsp_valid3), 32'd0);
        tick();
        chk("t4_held_valid", 32'(rsp_valid3), 32'd0);
        #3 i_rsn = 1'b1;
        req_valid3 = 1'b1; req_oper3 = 2'b01; req_a3 = 4'h6; req_b3 = 4'h9;
        status3 = 2'b00; result3 = 4'hB;
        tick();  // first edge after release
        req_valid3 = 1'b0;
        chk("t4_accept_oper", 32'(oper_o3), 32'h1);
        chk("t4_accept_argB", 32'(argb_o3), 32'h9);
        chk("t4_accept_ready", 32'(req_ready3), 32'd0);
        tick(); tick(); tick();
        chk("t4_no_early_valid", 32'(rsp_valid3), 32'd0);
        tick();
        chk("t4_valid_e4", 32'(rsp_valid3), 32'd1);
        chk("t4_result",   32'(rsp_result3), 32'hB);
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        chk("t4_err_after", 32'(err_cnt3), 32'd0);

        // ---------------- error counter saturation, 300 ops with status 01
        req_valid = 1'b1; rsp_ready = 1'b1; status = 2'b01; result = 4'h0;
        chk("t6_err_start", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 254 * 4; i++) tick();
        chk("t6_err_254", 32'(err_cnt), 32'd254);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_err_255", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 45 * 4; i++) tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("t6_err_sat", 32'(err_cnt), 32'd255);
        chk("t6_idle_end", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
